// File: rtl/tdm_delay_ctrl.sv
// ---------------------------------------------------------------------------
// tdm_delay_ctrl
//   Time-division-multiplexed delay line. CH interleaved channels share one
//   single-port RAM of CH*MAXD words. Channel c owns the region starting at
//   c*MAXD. It uses the first len[c] words of that region as a circular
//   buffer, so its output is delayed by len[c] of its own samples.
//   A per-channel fill counter masks stale RAM contents after reset or after
//   a reconfiguration.
//
// Ports
//   clk         rising-edge clock
//   rst         asynchronous active-high reset
//   en          sample strobe; din belongs to channel cur_ch
//   din         input sample
//   dout        delayed sample (registered, one clk after en)
//   dout_ch     channel index of dout
//   dout_valid  one-cycle pulse, the cycle after each accepted en
//   cfg_we      configuration write strobe
//   cfg_ch      channel being configured
//   cfg_len     new delay length (clamped to MAXD; 0 selects bypass)
//   cur_ch      channel that the next en sample is assigned to
// ---------------------------------------------------------------------------
module tdm_delay_ctrl #(
  parameter int DW   = 8,
  parameter int CH   = 4,
  parameter int MAXD = 32
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       en,
  input  logic [DW-1:0]              din,
  output logic [DW-1:0]              dout,
  output logic [$clog2(CH)-1:0]      dout_ch,
  output logic                       dout_valid,
  input  logic                       cfg_we,
  input  logic [$clog2(CH)-1:0]      cfg_ch,
  input  logic [$clog2(MAXD+1)-1:0]  cfg_len,
  output logic [$clog2(CH)-1:0]      cur_ch
);

  localparam int CW = $clog2(CH);
  localparam int PW = $clog2(MAXD);
  localparam int LW = $clog2(MAXD+1);
  localparam int AW = $clog2(CH*MAXD);
  localparam logic [AW-1:0] MAXD_A = AW'(MAXD);
  localparam logic [LW-1:0] MAXD_L = LW'(MAXD);
  localparam logic [CW-1:0] LAST_CH = CW'(CH-1);

  logic [LW-1:0] len_q  [CH];
  logic [PW-1:0] wptr_q [CH];
  logic [LW-1:0] fill_q [CH];
  logic [CW-1:0] ch_cnt;

  logic [DW-1:0] mem [CH*MAXD];

  function automatic logic [LW-1:0] sat_len(input logic [LW-1:0] l);
    return (l > MAXD_L) ? MAXD_L : l;
  endfunction

  // Stage p0: effective per-channel state for the current sample
  logic          hit_p0;
  logic [LW-1:0] len_p0;
  logic [PW-1:0] wptr_p0;
  logic [LW-1:0] fill_p0;
  logic [AW-1:0] addr_p0;
  logic          primed_p0;
  logic          bypass_p0;
  logic [PW-1:0] wptr_nx_p0;
  logic [LW-1:0] fill_nx_p0;
  logic [DW-1:0] rd_p0;

  always_comb begin
    // A configuration aimed at the channel being sampled takes effect first,
    // so the sample becomes the first one under the new length.
    hit_p0     = cfg_we && (cfg_ch == ch_cnt);
    len_p0     = hit_p0 ? sat_len(cfg_len) : len_q[ch_cnt];
    wptr_p0    = hit_p0 ? '0 : wptr_q[ch_cnt];
    fill_p0    = hit_p0 ? '0 : fill_q[ch_cnt];
    addr_p0    = AW'(ch_cnt) * MAXD_A + AW'(wptr_p0);
    bypass_p0  = (len_p0 == '0);
    primed_p0  = (fill_p0 >= len_p0);
    wptr_nx_p0 = (LW'(wptr_p0) == len_p0 - LW'(1)) ? '0 : wptr_p0 + PW'(1);
    fill_nx_p0 = primed_p0 ? fill_p0 : fill_p0 + LW'(1);
    rd_p0      = mem[addr_p0];
  end

  // Stage p1: registered output and state update
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ch_cnt     <= '0;
      dout       <= '0;
      dout_ch    <= '0;
      dout_valid <= 1'b0;
      for (int i = 0; i < CH; i++) begin
        len_q[i]  <= MAXD_L;
        wptr_q[i] <= '0;
        fill_q[i] <= '0;
      end
    end else begin
      dout_valid <= en;
      if (cfg_we) begin
        len_q[cfg_ch]  <= sat_len(cfg_len);
        wptr_q[cfg_ch] <= '0;
        fill_q[cfg_ch] <= '0;
      end
      if (en) begin
        ch_cnt  <= (ch_cnt == LAST_CH) ? '0 : ch_cnt + CW'(1);
        dout_ch <= ch_cnt;
        if (bypass_p0) begin
          dout <= din;
        end else begin
          dout           <= primed_p0 ? rd_p0 : '0;
          wptr_q[ch_cnt] <= wptr_nx_p0;
          fill_q[ch_cnt] <= fill_nx_p0;
        end
      end
    end
  end

  // RAM write half of the read-before-write access; contents are never reset.
  always_ff @(posedge clk) begin
    if (en && !bypass_p0) mem[addr_p0] <= din;
  end

  assign cur_ch = ch_cnt;

endmodule

// File: tb/tb_tdm_delay_ctrl.sv
module tb_tdm_delay_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic [7:0] din;
  logic [7:0] dout;
  logic [1:0] dout_ch;
  logic       dout_valid;
  logic       cfg_we;
  logic [1:0] cfg_ch;
  logic [5:0] cfg_len;
  logic [1:0] cur_ch;

  tdm_delay_ctrl #(.DW(8), .CH(4), .MAXD(32)) dut (
    .clk(clk), .rst(rst), .en(en), .din(din), .dout(dout), .dout_ch(dout_ch),
    .dout_valid(dout_valid), .cfg_we(cfg_we), .cfg_ch(cfg_ch),
    .cfg_len(cfg_len), .cur_ch(cur_ch)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int n;          // index of the next accepted sample; din = n mod 256
  int L[4];       // delay length per channel as the bench expects it
  int S[4];       // sample index of first sample since last (re)configuration
  int lastexp;
  int lastch;

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d (sample %0d)", tag, obs, exp, n);
    end
  endtask

  // Expected output for sample index m, from the delay definition.
  function automatic int expv(input int m);
    int c;
    int k;
    c = m % 4;
    if (L[c] == 0) return m & 255;
    k = (m - S[c]) / 4;
    if (k < L[c]) return 0;
    return (m - 4 * L[c]) & 255;
  endfunction

  // First sample index belonging to channel c at or after n.
  function automatic int next_n(input int c);
    return n + ((c - (n % 4) + 4) % 4);
  endfunction

  task automatic sample(input bit cw, input int cc, input int cl);
    int e;
    en      = 1'b1;
    din     = 8'(n);
    cfg_we  = cw;
    cfg_ch  = 2'(cc);
    cfg_len = 6'(cl);
    @(posedge clk);
    #1;
    en     = 1'b0;
    cfg_we = 1'b0;
    e = expv(n);
    chk("dout", dout, e);
    chk("dout_ch", dout_ch, n % 4);
    chk("dout_valid", dout_valid, 1);
    chk("cur_ch", cur_ch, (n + 1) % 4);
    lastexp = e;
    lastch  = n % 4;
    n++;
  endtask

  task automatic idle();
    @(posedge clk);
    #1;
    chk("idle_valid", dout_valid, 0);
    chk("idle_dout_hold", dout, lastexp);
    chk("idle_ch_hold", dout_ch, lastch);
  endtask

  task automatic cfg_only(input int c, input int l);
    cfg_we  = 1'b1;
    cfg_ch  = 2'(c);
    cfg_len = 6'(l);
    @(posedge clk);
    #1;
    cfg_we = 1'b0;
    chk("cfg_valid", dout_valid, 0);
    chk("cfg_cur_ch", cur_ch, n % 4);
  endtask

  task automatic init_model();
    n = 0;
    for (int c = 0; c < 4; c++) begin
      L[c] = 32;
      S[c] = c;
    end
    lastexp = 0;
    lastch  = 0;
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; din = '0; cfg_we = 1'b0; cfg_ch = '0; cfg_len = '0;
    init_model();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_dout", dout, 0);
    chk("rst_dout_ch", dout_ch, 0);
    chk("rst_valid", dout_valid, 0);
    chk("rst_cur_ch", cur_ch, 0);
    rst = 1'b0;

    // All channels at MAXD: 128 zero outputs, then n-128
    repeat (160) sample(0, 0, 0);

    // ch1=3, ch2=bypass, ch3=1; ch0 keeps 32
    L[1] = 3; S[1] = next_n(1); cfg_only(1, 3);
    L[2] = 0; S[2] = next_n(2); cfg_only(2, 0);
    L[3] = 1; S[3] = next_n(3); cfg_only(3, 1);
    repeat (40) sample(0, 0, 0);

    // Gapped strobes: one en in three cycles
    repeat (24) begin
      sample(0, 0, 0);
      idle();
      idle();
    end

    // Mid-stream ch1 -> 5, issued on a ch0 sample cycle
    while (n % 4 != 0) sample(0, 0, 0);
    L[1] = 5; S[1] = n + 1;
    sample(1, 1, 5);
    repeat (40) sample(0, 0, 0);

    // Config and sample on the same channel with an oversized length
    while (n % 4 != 2) sample(0, 0, 0);
    L[2] = 32; S[2] = n;
    sample(1, 2, 40);
    repeat (140) sample(0, 0, 0);

    // Asynchronous reset between clock edges
    #2;
    rst = 1'b1;
    #1;
    chk("arst_dout", dout, 0);
    chk("arst_valid", dout_valid, 0);
    chk("arst_dout_ch", dout_ch, 0);
    chk("arst_cur_ch", cur_ch, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    init_model();
    repeat (136) sample(0, 0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/tdm_delay_ctrl.md
Name: tdm_delay_ctrl

Overview:
- Time-division-multiplexed delay-line controller. One internal single-port RAM is shared among CH interleaved channels, and each channel has its own delay length that can be changed at runtime.
- Sits between a TDM sample source (samples arrive in round-robin channel order on an enable strobe) and downstream per-channel processing.
- Handles per-channel addressing, wrap-around, reconfiguration and priming, so users never manage RAM pointers.

Parameters:
- DW, 8, sample width in bits.
- CH, 4, number of interleaved channels (>=2).
- MAXD, 32, maximum delay per channel in samples (>=2); RAM depth is CH*MAXD.

Ports:
- clk  in  1  clock, all logic on rising edge.
- rst  in  1  asynchronous, active-high reset.
- en  in  1  sample strobe; din belongs to channel ch_cnt.
- din  in  DW  input sample.
- dout  out  DW  delayed sample, registered.
- dout_ch  out  $clog2(CH)  channel index of dout.
- dout_valid  out  1  one-cycle pulse, asserted the cycle after each accepted en.
- cfg_we  in  1  configuration write strobe.
- cfg_ch  in  $clog2(CH)  channel being configured.
- cfg_len  in  $clog2(MAXD+1)  new delay for cfg_ch, in that channel's samples.
- cur_ch  out  $clog2(CH)  channel the next en sample is assigned to (ch_cnt).

Behaviour:
- Reset (async, immediate):
  - ch_cnt=0; every len[c]=MAXD; every wptr[c]=0; every fill[c]=0.
  - dout=0, dout_ch=0, dout_valid=0.
  - RAM contents are not reset; stale data is masked by the fill logic.
- Channel sequencing:
  - Each en advances ch_cnt by 1, wrapping CH-1 -> 0.
  - When en=0, nothing changes and dout_valid=0. dout and dout_ch hold.
- Address: base(c)=c*MAXD; RAM address = base(ch_cnt)+wptr[ch_cnt].
- RAM access: read-before-write in the same cycle. The old word is captured and din is written at the same address.
- Pointer update: wptr[c] increments on each en for channel c and wraps to 0 when it reaches len[c]-1, so channel c uses locations base..base+len-1.
- Delay: on the k-th en for channel c, dout equals the din given at the (k-len[c])-th en for c. Latency to dout is 1 clk (registered).
- len=0: bypass. dout = din registered 1 clk. No RAM write, and wptr is unchanged.
- len=1: dout is the previous sample of the same channel.
- Fill masking:
  - fill[c] counts accepted samples for c since reset or the last reconfiguration, saturating at len[c].
  - While fill[c] < len[c], dout=0 for that channel (still valid-pulsed).
- Reconfiguration (cfg_we=1):
  - len[cfg_ch] = min(cfg_len, MAXD); wptr[cfg_ch]=0; fill[cfg_ch]=0.
  - Other channels are unaffected, and ch_cnt is unaffected.
- Simultaneous cfg_we and en on the same channel: the config applies first. The sample is treated as the first sample under the new length: written at base+0, dout=0, wptr becomes 1 (or wraps to 0 if new len=1), fill becomes 1.
- Simultaneous cfg_we and en on different channels: both take effect independently.
- Widths: all pointer arithmetic uses unsigned $clog2(MAXD) bits. base is computed at full address width $clog2(CH*MAXD) with no truncation.

Test Plan:
- Reset, then CH=4, MAXD=32, all len=32. Drive en every cycle with din=n (n=0,1,2,...) -> dout=0 for the first 128 strobes. Afterwards, dout at strobe n equals n-128 mod 256, and dout_ch cycles 0,1,2,3 one clk behind cur_ch.
- cfg ch1 len=3, ch2 len=0, ch3 len=1; ch0 stays 32. Stream din=n -> ch2 output equals its own input 1 clk later; ch3 output equals its previous sample (n-4) after 1 fill; ch1 output is delayed by 3 ch1-samples (n-12) after 3 zero outputs; ch0 is unchanged.
- en gapped (1 of every 3 cycles) -> same outputs as the previous scenario, with dout_valid only on the cycle after each en.
- Mid-stream cfg ch1 len=5 while steady -> the next 5 ch1 outputs are 0, then the delay is 5 samples. ch0, ch2 and ch3 outputs are uninterrupted.
- cfg_we and en in the same cycle for the same channel, cfg_len=40 (>MAXD) -> len clamps to 32; that sample's dout=0; its value reappears 32 channel-samples later.
- Assert rst mid-stream between clock edges -> outputs go to 0 immediately; after release, ch_cnt restarts at 0 and all channels re-prime with 32 zero outputs.
